// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: digit width, FSM states,
// the saturation digit and a decimal power helper used for range checks.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_t;

    function automatic longint unsigned dec_pow(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/bin_para_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per
// cycle; values above 10^DIGITS-1 saturate to all nines and flag overflow.
module bin_para_bcd
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          overflow
);

    localparam int SCR_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam longint unsigned MAX_DEC = dec_pow(DIGITS) - 64'd1;
    localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

    if (MAX_BIN < MAX_DEC) begin : g_width_check
        $error("bin_para_bcd: WIDTH too small to hold 10^DIGITS-1");
    end

    bcd_state_t       state_q, state_d;
    logic [WIDTH-1:0] shift_q;
    logic [SCR_W-1:0] scratch_q;
    logic [SCR_W-1:0] scratch_adj;
    logic [SCR_W-1:0] scratch_nxt;
    logic [WIDTH-1:0] shift_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             in_ovf;
    logic             last_iter;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_in  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Correct all digits first, then shift {scratch, binary} left as one word.
    assign scratch_nxt = {scratch_adj[SCR_W-2:0], shift_q[WIDTH-1]};
    assign shift_nxt   = {shift_q[WIDTH-2:0], 1'b0};
    assign in_ovf      = 64'(bin_in) > MAX_DEC;
    assign last_iter   = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? SHIFT : IDLE;
            SHIFT:      state_d = last_iter ? DONE : SHIFT;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    // Overflow is decided at accept time so the result load needs no compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        shift_q   <= bin_in;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        ovf_q     <= in_ovf;
                    end
                end
                SHIFT: begin
                    shift_q   <= shift_nxt;
                    scratch_q <= scratch_nxt;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        bcd_out  <= ovf_q ? {DIGITS{BCD_NINE}} : scratch_nxt;
                        overflow <= ovf_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_para_bcd.sv
// Self-checking bench for bin_para_bcd: directed boundary cases plus random
// values compared against a divide/modulo decimal reference.
module tb_bin_para_bcd;

    logic        clk;
    logic        reset;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    int pass_cnt;
    int total_cnt;
    int fail_cnt;

    bin_para_bcd #(.WIDTH(14), .DIGITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int p;
        if (v > 9999) return 16'h9999;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts one conversion and follows it to done; optionally pulses a
    // competing start mid-conversion that must be ignored.
    task automatic applyStimulus(input int value, input int inj_cycle);
        logic [15:0] held;
        logic [15:0] exp;
        bit stable, busy_ok, digits_ok;
        int lat;
        held    = bcd_out;
        stable  = 1'b1;
        busy_ok = 1'b1;
        lat     = -1;
        start   = 1'b1;
        bin_in  = 14'(value);
        for (int c = 1; c <= 40; c++) begin
            step();
            start = 1'b0;
            if (c == inj_cycle) begin
                start  = 1'b1;
                bin_in = 14'd7777;
            end
            if (done) begin
                lat = c;
                break;
            end
            if (bcd_out !== held) stable = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        exp = ref_bcd(value);
        digits_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bcd_out[4*i +: 4] > 4'd9) digits_ok = 1'b0;
        end
        checkOutput($sformatf("latency(%0d)", value), 64'(lat), 64'd15);
        checkOutput($sformatf("busy_window(%0d)", value), 64'(busy_ok), 64'd1);
        checkOutput($sformatf("held_before_done(%0d)", value), 64'(stable), 64'd1);
        checkOutput($sformatf("bcd(%0d)", value), 64'(bcd_out), 64'(exp));
        checkOutput($sformatf("overflow(%0d)", value), 64'(overflow), 64'(value > 9999));
        checkOutput($sformatf("digits_valid(%0d)", value), 64'(digits_ok), 64'd1);
        checkOutput($sformatf("busy_at_done(%0d)", value), 64'(busy), 64'd0);
    endtask

    task automatic checkHold(input logic [15:0] exp_bcd, input logic exp_ovf);
        step();
        checkOutput("done_single_pulse", 64'(done), 64'd0);
        checkOutput("bcd_hold", 64'(bcd_out), 64'(exp_bcd));
        checkOutput("ovf_hold", 64'(overflow), 64'(exp_ovf));
    endtask

    initial begin
        int v;
        bit no_done;
        pass_cnt  = 0;
        total_cnt = 0;
        fail_cnt  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;

        repeat (3) begin
            step();
            checkOutput("rst_busy", 64'(busy), 64'd0);
            checkOutput("rst_done", 64'(done), 64'd0);
        end
        reset = 1'b0;
        repeat (2) begin
            step();
            checkOutput("idle_busy", 64'(busy), 64'd0);
            checkOutput("idle_done", 64'(done), 64'd0);
            checkOutput("idle_bcd", 64'(bcd_out), 64'h0);
            checkOutput("idle_ovf", 64'(overflow), 64'd0);
        end

        applyStimulus(1234, 0);
        checkHold(16'h1234, 1'b0);

        applyStimulus(0, 0);
        checkHold(16'h0000, 1'b0);
        applyStimulus(9999, 0);
        checkHold(16'h9999, 1'b0);
        applyStimulus(10000, 0);
        checkHold(16'h9999, 1'b1);
        applyStimulus(16383, 0);
        checkHold(16'h9999, 1'b1);

        // Ignored mid-conversion start, then a back-to-back start in DONE.
        applyStimulus(42, 5);
        applyStimulus(305, 0);
        checkHold(16'h0305, 1'b0);

        start  = 1'b1;
        bin_in = 14'd5678;
        for (int c = 1; c <= 7; c++) begin
            step();
            start = 1'b0;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_bcd", 64'(bcd_out), 64'h0);
        checkOutput("abort_ovf", 64'(overflow), 64'd0);
        no_done = 1'b1;
        repeat (20) begin
            step();
            if (done !== 1'b0) no_done = 1'b0;
        end
        checkOutput("abort_no_done", 64'(no_done), 64'd1);
        applyStimulus(99, 0);
        checkHold(16'h0099, 1'b0);

        for (int n = 0; n < 150; n++) begin
            v = int'($urandom_range(0, 9999));
            applyStimulus(v, 0);
            checkHold(ref_bcd(v), 1'b0);
        end
        for (int n = 0; n < 20; n++) begin
            v = int'($urandom_range(0, 16383));
            applyStimulus(v, (n % 3 == 0) ? 3 + n % 10 : 0);
            checkHold(ref_bcd(v), v > 9999);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bin_para_bcd.md
# bin_para_bcd

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly upstream of the seven-segment decoders: it takes an unsigned binary value and produces `DIGITS` packed 4-bit BCD digits, each driving one decoder instance. Values that cannot be shown in `DIGITS` decimal digits saturate to all nines and raise an overflow flag.

## Interface
- `WIDTH`, default 14: binary input width. Constraint: 2^WIDTH − 1 ≥ 10^DIGITS − 1; elaboration error otherwise.
- `DIGITS`, default 4: number of BCD digits produced.
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a conversion of `bin_in`; accepted only when `busy` = 0.
- `bin_in` in WIDTH: unsigned value; sampled only on the accepted `start` cycle.
- `busy` out 1: conversion in progress.
- `done` out 1: one-cycle pulse; `bcd_out`/`overflow` updated in the same cycle.
- `bcd_out` out 4·DIGITS: packed digits, digit 0 (units) in bits [3:0]; held between completions.
- `overflow` out 1: last converted value exceeded 10^DIGITS − 1; held with `bcd_out`.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `busy`=0, `done`=0. If `start`=1: latch `bin_in` into the shift register, clear the BCD scratch register, set the counter to 0, compute the overflow flag (`bin_in` > 10^DIGITS − 1), and go to SHIFT.
- SHIFT: `busy`=1. Each cycle performs one iteration:
  - Every scratch digit ≥ 5 gets +3; digits ≤ 4 are unchanged.
  - The {scratch, binary} register then shifts left by 1.
  - The counter increments.
  - After exactly WIDTH iterations, load `bcd_out` and `overflow`, and go to DONE.
  - On overflow, `bcd_out` loads all digits = 9 instead of the scratch register.
- DONE: `done`=1 for this cycle only, `busy`=0.
  - `start`=1 in DONE is accepted exactly as in IDLE, giving back-to-back conversions; otherwise go to IDLE.
- `start` while in SHIFT is ignored. It is not queued, and `bin_in` changes have no effect.
- Scratch register width: 4·DIGITS bits. Bits shifted out of the top are discarded; this only happens in the overflow case, whose result is replaced anyway.
- Counter width: $clog2(WIDTH+1).
- Reset, from any state including mid-SHIFT: aborts the conversion and goes to IDLE.
  - Reset values: `busy`=0, `done`=0, `overflow`=0, `bcd_out`=0 (all digits read 0).
  - Internal registers are cleared.
- `bcd_out` never shows intermediate scratch values.

## Timing
- Cycle 0: `start` sampled high while `busy` = 0.
- Cycles 1..WIDTH: `busy`=1; one iteration per cycle.
- Cycle WIDTH+1: `done`=1, with new `bcd_out`/`overflow` visible. For the default WIDTH = 14 this is cycle 15.
- Latency is fixed at WIDTH+1 cycles from `start` to `done`, independent of value or overflow.
- Throughput: one conversion per WIDTH+1 cycles when `start` is reasserted in the DONE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `bcd_pkg`:
  - `BCD_DIGIT_W` = 4
  - State enum `bcd_state_t` {IDLE, SHIFT, DONE}
  - Constant `BCD_NINE` = 4'd9, used for saturation.
- Sub-module `bcd_add3`:
  - Combinational: 4-bit digit in, 4-bit digit out; adds 3 if the input is ≥ 5.
  - Instantiated DIGITS times in a generate loop.
- Top level holds the FSM, the iteration counter, the shift/scratch registers and the output registers.

## Test plan
- Reset held 3 cycles, then released with `start`=0: `busy`=0, `done`=0, `overflow`=0, `bcd_out`=16'h0000 throughout.
- `start` with `bin_in`=1234: `busy` high cycles 1–14; `done` pulses exactly at cycle 15 with `bcd_out`=16'h1234 and `overflow`=0; the value holds after `done` drops.
- Boundary values:
  - `bin_in`=0 → 16'h0000.
  - 9999 → 16'h9999 with `overflow`=0.
  - 10000 → 16'h9999 with `overflow`=1.
  - 16383 → 16'h9999 with `overflow`=1.
  - Every case completes in 15 cycles.
- Ignored `start`: convert 0042, pulse `start` with `bin_in`=7777 at cycle 5 → result 16'h0042 at cycle 15. Then `start` asserted in the DONE cycle with 0305 → next `done` 15 cycles later with 16'h0305.
- Reset at cycle 7 of a 5678 conversion:
  - Next cycle: IDLE, `bcd_out`=0, no `done` pulse.
  - A new `start` with 0099 → 16'h0099 after 15 cycles.
- Sweep 0..9999 against a reference model. Checks per conversion:
  - Each digit ≤ 9.
  - Exactly one `done` pulse.
  - `bcd_out` stable whenever `done` = 0.
